// File: rtl/vga_timing_pkg.sv
// Shared VGA timing definitions for the generator and receiver sides.
// Holds the default 640x480@60 constants (800 x 525 totals) and the
// receiver lock-FSM state type.
package vga_timing_pkg;

    // Horizontal timing, pixel clocks
    localparam int unsigned VgaHSync  = 96;
    localparam int unsigned VgaHBp    = 48;
    localparam int unsigned VgaHAct   = 640;
    localparam int unsigned VgaHFp    = 16;
    localparam int unsigned VgaHTotal = VgaHSync + VgaHBp + VgaHAct + VgaHFp;

    // Vertical timing, lines
    localparam int unsigned VgaVSync  = 2;
    localparam int unsigned VgaVBp    = 33;
    localparam int unsigned VgaVAct   = 480;
    localparam int unsigned VgaVFp    = 10;
    localparam int unsigned VgaVTotal = VgaVSync + VgaVBp + VgaVAct + VgaVFp;

    // Receiver mode-lock state
    typedef enum logic [1:0] {
        StSearch,
        StMeasure,
        StLocked
    } rx_state_e;

endpackage

// File: rtl/sync_edge_detect.sv
// Brings one asynchronous active-low sync input into the clk_25MHz domain
// and flags its assertion (high-to-low) edge.
//   clk_25MHz   : pixel clock
//   rst_n       : asynchronous active-low reset (all stages reset high = idle)
//   sync_in_n   : raw asynchronous sync, low = asserted
//   sync_n      : synchronized level
//   assert_edge : one-cycle pulse when the synchronized level falls
module sync_edge_detect (
    input  logic clk_25MHz,
    input  logic rst_n,
    input  logic sync_in_n,
    output logic sync_n,
    output logic assert_edge
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= sync_in_n;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign sync_n      = sync_q;
    assign assert_edge = ~sync_q & prev_q;

endmodule

// File: rtl/vga_sync_receiver.sv
// VGA sync receiver: measures line length (clocks) and frame length (lines)
// from external hsync/vsync, locks after LOCK_FRAMES consecutive matching
// frames, then reconstructs pixel coordinates and an active-video flag.
//   clk_25MHz, rst_n   : pixel clock, asynchronous active-low reset
//   hsync_n, vsync_n   : asynchronous active-low syncs
//   locked             : mode locked
//   h_total, v_total   : last measured line length / frame length
//   pixel_x, pixel_y   : active-area coordinates, zero outside active video
//   video_on           : active area and locked
//   frame_start        : one-cycle pulse per vsync assertion edge
module vga_sync_receiver
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_SYNC      = VgaHSync,
    parameter int unsigned H_BP        = VgaHBp,
    parameter int unsigned H_ACT       = VgaHAct,
    parameter int unsigned V_SYNC      = VgaVSync,
    parameter int unsigned V_BP        = VgaVBp,
    parameter int unsigned V_ACT       = VgaVAct,
    parameter int unsigned LOCK_FRAMES = 2,
    parameter int unsigned H_TIMEOUT   = 4095,
    parameter int unsigned V_TIMEOUT   = 2047
) (
    input  logic        clk_25MHz,
    input  logic        rst_n,
    input  logic        hsync_n,
    input  logic        vsync_n,
    output logic        locked,
    output logic [15:0] h_total,
    output logic [15:0] v_total,
    output logic [15:0] pixel_x,
    output logic [15:0] pixel_y,
    output logic        video_on,
    output logic        frame_start
);

    localparam logic [15:0] HStart     = 16'(H_SYNC + H_BP);
    localparam logic [15:0] HEnd       = 16'(H_SYNC + H_BP + H_ACT);
    localparam logic [15:0] VStart     = 16'(V_SYNC + V_BP);
    localparam logic [15:0] VEnd       = 16'(V_SYNC + V_BP + V_ACT);
    localparam logic [15:0] HTimeout   = 16'(H_TIMEOUT);
    localparam logic [15:0] VTimeout   = 16'(V_TIMEOUT);
    localparam logic [15:0] LockFrames = 16'(LOCK_FRAMES);

    logic hs_level, vs_level, hs_edge, vs_edge;
    logic unused_levels;

    sync_edge_detect u_hsync (
        .clk_25MHz   (clk_25MHz),
        .rst_n       (rst_n),
        .sync_in_n   (hsync_n),
        .sync_n      (hs_level),
        .assert_edge (hs_edge)
    );

    sync_edge_detect u_vsync (
        .clk_25MHz   (clk_25MHz),
        .rst_n       (rst_n),
        .sync_in_n   (vsync_n),
        .sync_n      (vs_level),
        .assert_edge (vs_edge)
    );

    // Only the edges are used; pulse widths are not measured.
    assign unused_levels = hs_level ^ vs_level;

    rx_state_e   state_q, state_d;
    logic [15:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    logic [15:0] h_prev_q, h_prev_d, match_cnt_q, match_cnt_d;
    logic [15:0] h_total_q, h_total_d, v_total_q, v_total_d;
    logic        hold_q, hold_d, h_unstable_q, h_unstable_d;

    logic [15:0] line_len, frame_len;
    logic        unstable_now, match, timeout;
    logic        in_h, in_v, video_d;

    assign line_len  = h_cnt_q + 16'd1;
    // A line ending together with the vsync edge still belongs to the old frame.
    assign frame_len    = hs_edge ? v_cnt_q + 16'd1 : v_cnt_q;
    assign unstable_now = h_unstable_q | (hs_edge & (line_len != h_prev_q));
    assign match        = (frame_len == v_total_q) & ~unstable_now;
    assign timeout      = (h_cnt_q == HTimeout) | (v_cnt_q == VTimeout);

    // Line / frame counters
    always_comb begin
        h_cnt_d   = h_cnt_q;
        v_cnt_d   = v_cnt_q;
        hold_d    = hold_q;
        h_total_d = h_total_q;
        if (timeout) begin
            // Park both counters at zero until sync activity resumes.
            h_cnt_d = '0;
            v_cnt_d = '0;
            hold_d  = 1'b1;
        end else begin
            if (hs_edge) begin
                h_cnt_d   = '0;
                h_total_d = line_len;
                v_cnt_d   = v_cnt_q + 16'd1;
            end else if (!hold_q) begin
                h_cnt_d = h_cnt_q + 16'd1;
            end
            if (vs_edge) begin
                v_cnt_d = '0;
            end
            if (hs_edge || vs_edge) begin
                hold_d = 1'b0;
            end
        end
    end

    // Lock FSM and stability tracking
    always_comb begin
        state_d      = state_q;
        h_prev_d     = h_prev_q;
        h_unstable_d = h_unstable_q;
        match_cnt_d  = match_cnt_q;
        v_total_d    = v_total_q;
        if (hs_edge) begin
            h_prev_d     = line_len;
            h_unstable_d = unstable_now;
        end
        if (vs_edge) begin
            h_unstable_d = 1'b0;
        end
        case (state_q)
            StSearch: begin
                v_total_d   = '0;
                h_prev_d    = '0;
                match_cnt_d = '0;
                if (vs_edge) begin
                    state_d = StMeasure;
                end
            end
            StMeasure: begin
                if (vs_edge) begin
                    v_total_d = frame_len;
                    if (match) begin
                        match_cnt_d = match_cnt_q + 16'd1;
                        if (match_cnt_q + 16'd1 >= LockFrames) begin
                            state_d = StLocked;
                        end
                    end else begin
                        match_cnt_d = '0;
                    end
                end
            end
            StLocked: begin
                if (vs_edge) begin
                    v_total_d = frame_len;
                    if (!match) begin
                        state_d     = StMeasure;
                        match_cnt_d = '0;
                    end
                end
            end
            default: state_d = StSearch;
        endcase
        if (timeout) begin
            state_d = StSearch;
        end
    end

    assign in_h    = (h_cnt_q >= HStart) && (h_cnt_q < HEnd);
    assign in_v    = (v_cnt_q >= VStart) && (v_cnt_q < VEnd);
    assign video_d = (state_q == StLocked) && in_h && in_v;

    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StSearch;
            h_cnt_q      <= '0;
            v_cnt_q      <= '0;
            hold_q       <= 1'b0;
            h_prev_q     <= '0;
            h_unstable_q <= 1'b0;
            match_cnt_q  <= '0;
            h_total_q    <= '0;
            v_total_q    <= '0;
            locked       <= 1'b0;
            video_on     <= 1'b0;
            pixel_x      <= '0;
            pixel_y      <= '0;
            frame_start  <= 1'b0;
        end else begin
            state_q      <= state_d;
            h_cnt_q      <= h_cnt_d;
            v_cnt_q      <= v_cnt_d;
            hold_q       <= hold_d;
            h_prev_q     <= h_prev_d;
            h_unstable_q <= h_unstable_d;
            match_cnt_q  <= match_cnt_d;
            h_total_q    <= h_total_d;
            v_total_q    <= v_total_d;
            locked       <= (state_d == StLocked);
            video_on     <= video_d;
            pixel_x      <= video_d ? h_cnt_q - HStart : 16'd0;
            pixel_y      <= video_d ? v_cnt_q - VStart : 16'd0;
            frame_start  <= vs_edge;
        end
    end

    assign h_total = h_total_q;
    assign v_total = v_total_q;

endmodule

// File: doc/vga_sync_receiver.md
# vga_sync_receiver

Receive-side counterpart of the VGA timing generator: takes external active-low hsync/vsync, synchronizes them into the 25 MHz domain, and measures line length in clocks and frame length in lines. Locks onto a stable mode and then reconstructs pixel coordinates and an active-video flag for downstream capture/checking logic. Used as a loop-back checker for the generator and as the front end of any VGA input path.

## Interface
- H_SYNC, default 96: hsync pulse width, clocks
- H_BP, default 48: horizontal back porch, clocks
- H_ACT, default 640: active pixels per line
- V_SYNC, default 2: vsync pulse width, lines
- V_BP, default 33: vertical back porch, lines
- V_ACT, default 480: active lines per frame
- LOCK_FRAMES, default 2: consecutive matching frames required for lock
- H_TIMEOUT, default 4095: h_cnt value that forces loss of lock
- V_TIMEOUT, default 2047: v_cnt value that forces loss of lock
- clk_25MHz  in  1  pixel clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- hsync_n  in  1  asynchronous hsync, low = sync asserted
- vsync_n  in  1  asynchronous vsync, low = sync asserted
- locked  out  1  mode locked
- h_total  out  16  last measured line length, clocks
- v_total  out  16  last measured frame length, lines
- pixel_x  out  16  active-area column, valid when video_on
- pixel_y  out  16  active-area row, valid when video_on
- video_on  out  1  current clock is in active area (and locked)
- frame_start  out  1  one-cycle pulse on each vsync assertion edge

## Operation
- Each sync input: 2-FF synchronizer, then third register; assertion edge = q2 low and q3 high.
- h_cnt (16 b): on hsync edge h_cnt <= 0 and h_total <= h_cnt + 1; otherwise increment.
- v_cnt (16 b): increments on each hsync edge. On vsync edge v_cnt <= 0; v_total captured as v_cnt + 1 if hsync edge in same cycle, else v_cnt.
- h stability: h_prev latched on each hsync edge; h_unstable set if new line length != h_prev; cleared on vsync edge after evaluation.
- match = (new v_total == previous v_total) and not h_unstable.
- FSM states SEARCH, MEASURE, LOCKED:
  - SEARCH: locked=0; v_total/h_prev/match_cnt cleared; vsync edge -> MEASURE (no capture).
  - MEASURE: each vsync edge captures v_total; match -> match_cnt+1, else match_cnt=0; match_cnt reaching LOCK_FRAMES -> LOCKED.
  - LOCKED: vsync edge with no match -> MEASURE, match_cnt=0.
  - Any state: h_cnt == H_TIMEOUT or v_cnt == V_TIMEOUT -> SEARCH, h_cnt/v_cnt held at 0 until next edge.
- video_on = locked and H_SYNC+H_BP <= h_cnt < H_SYNC+H_BP+H_ACT and V_SYNC+V_BP <= v_cnt < V_SYNC+V_BP+V_ACT.
- pixel_x = h_cnt - (H_SYNC+H_BP), pixel_y = v_cnt - (V_SYNC+V_BP); outputs forced 0 when video_on low.
- Arithmetic unsigned, 16 b, no wrap reachable (timeouts < 2^16).

## Timing
- Reset: state SEARCH; all outputs, counters, synchronizers (reset to 1) cleared; locked=0.
- Sync input low sampled at edge k -> edge detected in cycle after edge k+1 -> h_cnt reads 0 after edge k+2.
- locked, video_on, pixel_x/y, frame_start, h_total, v_total registered: one cycle after the counter/edge state they reflect.
- Sync deassertion edges ignored; pulse widths not measured.
- Reset mid-frame: immediate return to reset values; lock reacquisition restarts from SEARCH.
- With default LOCK_FRAMES and clean input: locked rises one cycle after 4th vsync edge detect (edge 1 enters MEASURE, 2 mismatches against cleared value, 3 and 4 match).

## Structure
- Package vga_timing_pkg: FSM state enum, default 640x480 constants (800/525 totals, porches, sync widths), shared with the generator side.
- Sub-module sync_edge_detect (2-FF sync + edge register, outputs synchronized level and assertion pulse), instantiated for hsync_n and vsync_n.

## Test plan
- Clean 640x480 stream from generator timing (800 x 525, syncs aligned) -> h_total=800, v_total=525, locked after 4th vsync edge, frame_start every 420000 clocks.
- Locked stream, sample first active pixel -> video_on high, pixel_x=0, pixel_y=0; last active -> pixel_x=639, pixel_y=479; count of video_on cycles per frame = 307200.
- Single line of 801 clocks in a locked frame -> next vsync edge drops locked (MEASURE), relocks after 2 further clean frames.
- hsync_n held high -> h_cnt hits 4095 -> SEARCH, locked=0, video_on=0.
- rst_n pulsed low mid-frame while locked -> all outputs 0 asynchronously; relock after 4 vsync edges.
- Frame of 524 lines between clean frames -> v_total=524 captured, lock lost, v_total returns to 525 next frame.
